// File: rtl/jtframe_ioctl2prog_if.sv
// rtl/jtframe_ioctl2prog_if.sv - loader byte stream in, SDRAM programming port out
interface jtframe_ioctl2prog_if #(
  parameter int SDRAMW = 23
);
  logic              downloading;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_data;
  logic              ioctl_wr;
  logic [SDRAMW-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic [1:0]        prog_mask;
  logic [1:0]        prog_ba;
  logic              prog_we;
  logic              prog_ack;
  logic              dwnld_busy;
  logic              overflow;

  modport master (
    output downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_ack,
    input  prog_addr, prog_data, prog_mask, prog_ba, prog_we, dwnld_busy, overflow
  );

  modport slave (
    input  downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_ack,
    output prog_addr, prog_data, prog_mask, prog_ba, prog_we, dwnld_busy, overflow
  );
endinterface

// File: rtl/jtframe_ioctl2prog.sv
// rtl/jtframe_ioctl2prog.sv - packs loader bytes into banked 16-bit SDRAM writes
// One even byte is held for pairing; completed words queue in a 4-entry FIFO.
module jtframe_ioctl2prog #(
  parameter int          SDRAMW    = 23,
  parameter logic [24:0] BA1_START = 25'h040_0000,
  parameter logic [24:0] BA2_START = 25'h080_0000,
  parameter logic [24:0] BA3_START = 25'h0C0_0000
) (
  input logic                 clk,
  input logic                 rst_n,
  jtframe_ioctl2prog_if.slave bus
);
  typedef struct packed {
    logic [SDRAMW-1:0] addr;
    logic [1:0]        ba;
    logic [15:0]       data;
    logic [1:0]        mask;
  } entry_t;

  function automatic entry_t make_entry(input logic [24:0] a, input logic [7:0] lo,
                                        input logic [7:0] hi, input logic [1:0] mask);
    entry_t      e;
    logic [24:0] start;
    logic [24:0] word;
    if (a >= BA3_START) begin
      e.ba = 2'd3; start = BA3_START;
    end else if (a >= BA2_START) begin
      e.ba = 2'd2; start = BA2_START;
    end else if (a >= BA1_START) begin
      e.ba = 2'd1; start = BA1_START;
    end else begin
      e.ba = 2'd0; start = 25'd0;
    end
    word   = (a - start) >> 1;
    e.addr = word[SDRAMW-1:0];
    e.data = {hi, lo};
    e.mask = mask;
    return e;
  endfunction

  entry_t      fifo_mem [4];
  entry_t      head_q;
  logic [1:0]  rd_ptr, wr_ptr;
  logic [2:0]  count;
  logic        hold_valid;
  logic [24:0] hold_addr;
  logic [7:0]  hold_data;
  logic        dl_q, prog_we_q, busy_q, overflow_q;

  entry_t      push_ent [3];
  logic [1:0]  push_num;
  logic        hold_valid_nx;
  logic [24:0] hold_addr_nx;
  logic [7:0]  hold_data_nx;

  logic        pop, drop;
  logic [1:0]  rd_nx, wr_nx;
  logic [2:0]  occ_pop, occ_nx;
  logic [2:0]  wen;
  logic [1:0]  waddr [3];

  // Byte pairing: builds up to three ordered pushes (two from the byte, one from a flush)
  always_comb begin
    hold_valid_nx = hold_valid;
    hold_addr_nx  = hold_addr;
    hold_data_nx  = hold_data;
    push_num      = 2'd0;
    for (int i = 0; i < 3; i++) push_ent[i] = '0;
    if (bus.ioctl_wr) begin
      if (!bus.ioctl_addr[0]) begin
        if (hold_valid) begin
          push_ent[push_num] = make_entry(hold_addr, hold_data, hold_data, 2'b10);
          push_num = push_num + 2'd1;
        end
        hold_valid_nx = 1'b1;
        hold_addr_nx  = bus.ioctl_addr;
        hold_data_nx  = bus.ioctl_data;
      end else if (hold_valid && bus.ioctl_addr == hold_addr + 25'd1) begin
        push_ent[push_num] = make_entry(hold_addr, hold_data, bus.ioctl_data, 2'b00);
        push_num = push_num + 2'd1;
        hold_valid_nx = 1'b0;
      end else begin
        if (hold_valid) begin
          push_ent[push_num] = make_entry(hold_addr, hold_data, hold_data, 2'b10);
          push_num = push_num + 2'd1;
        end
        push_ent[push_num] = make_entry(bus.ioctl_addr, bus.ioctl_data, bus.ioctl_data, 2'b01);
        push_num = push_num + 2'd1;
        hold_valid_nx = 1'b0;
      end
    end
    if (dl_q && !bus.downloading && hold_valid_nx) begin
      push_ent[push_num] = make_entry(hold_addr_nx, hold_data_nx, hold_data_nx, 2'b10);
      push_num = push_num + 2'd1;
      hold_valid_nx = 1'b0;
    end
  end

  // A pop in the same cycle frees its slot before pushes are accepted
  always_comb begin
    pop     = prog_we_q & bus.prog_ack;
    rd_nx   = rd_ptr + {1'b0, pop};
    occ_pop = count - {2'b00, pop};
    occ_nx  = occ_pop;
    wr_nx   = wr_ptr;
    drop    = 1'b0;
    wen     = '0;
    for (int i = 0; i < 3; i++) waddr[i] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < push_num) begin
        if (occ_nx < 3'd4) begin
          wen[i]   = 1'b1;
          waddr[i] = wr_nx;
          wr_nx    = wr_nx + 2'd1;
          occ_nx   = occ_nx + 3'd1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (wen[i]) fifo_mem[waddr[i]] <= push_ent[i];
  end

  // Head is registered from the post-pop state, so a fresh push shows one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid  <= 1'b0;
      hold_addr   <= '0;
      hold_data   <= '0;
      dl_q        <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      prog_we_q   <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      head_q      <= '0;
      head_q.mask <= 2'b11;
    end else begin
      hold_valid <= hold_valid_nx;
      hold_addr  <= hold_addr_nx;
      hold_data  <= hold_data_nx;
      dl_q       <= bus.downloading;
      rd_ptr     <= rd_nx;
      wr_ptr     <= wr_nx;
      count      <= occ_nx;
      prog_we_q  <= occ_pop != 3'd0;
      head_q     <= fifo_mem[rd_nx];
      overflow_q <= overflow_q | drop;
      busy_q     <= bus.downloading | hold_valid_nx | (occ_nx != 3'd0);
    end
  end

  assign bus.prog_addr  = head_q.addr;
  assign bus.prog_data  = head_q.data;
  assign bus.prog_mask  = head_q.mask;
  assign bus.prog_ba    = head_q.ba;
  assign bus.prog_we    = prog_we_q;
  assign bus.dwnld_busy = busy_q;
  assign bus.overflow   = overflow_q;
endmodule
